// File: rtl/clownfish_mem_arbiter_v3.sv
// clownfish_mem_arbiter_v3
// Arbitrates NUM_REQ L1/DMA requesters onto the single external PAE memory port.
// One transaction is in flight at a time. The grant is round-robin or fixed-priority.
// Each port supplies its own upper physical address bits.
// A response that never arrives is turned into an error return after TIMEOUT_CYC cycles.
// Memory responses that show up while idle are drained and dropped.
module clownfish_mem_arbiter_v3 #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 32,
    parameter int PADDR_W     = 36,
    parameter int DATA_W      = 512,
    parameter int RR_MODE     = 1,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_REQ-1:0]                   req_valid_i,
    input  logic [NUM_REQ*ADDR_W-1:0]            req_addr_i,
    input  logic [NUM_REQ-1:0]                   req_we_i,
    input  logic [NUM_REQ*DATA_W-1:0]            req_data_i,
    input  logic [NUM_REQ*(PADDR_W-ADDR_W)-1:0]  pae_hi_i,
    output logic [NUM_REQ-1:0]                   req_ready_o,
    output logic [NUM_REQ-1:0]                   resp_valid_o,
    output logic [DATA_W-1:0]                    resp_data_o,
    output logic                                 resp_error_o,
    input  logic [NUM_REQ-1:0]                   resp_ready_i,
    output logic                                 mem_req_valid_o,
    output logic [PADDR_W-1:0]                   mem_req_addr_o,
    output logic                                 mem_req_we_o,
    output logic [DATA_W-1:0]                    mem_req_data_o,
    input  logic                                 mem_req_ready_i,
    input  logic                                 mem_resp_valid_i,
    input  logic [DATA_W-1:0]                    mem_resp_data_i,
    input  logic                                 mem_resp_error_i,
    output logic                                 mem_resp_ready_o,
    output logic                                 busy_o,
    output logic                                 timeout_o
);

    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HI_W    = PADDR_W - ADDR_W;
    localparam int CNT_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int TO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

    typedef enum logic [1:0] {IDLE, REQ, RESP, TOERR} state_t;

    state_t              state;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     id_q;
    logic [PADDR_W-1:0]  paddr_q;
    logic                we_q;
    logic [DATA_W-1:0]   data_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                grant_found;
    logic [ID_W-1:0]     grant_id;
    logic [ID_W-1:0]     scan_idx;
    int                  scan_start;
    logic [PADDR_W-1:0]  sel_paddr;
    logic                sel_we;
    logic [DATA_W-1:0]   sel_data;
    logic                resp_hs;
    logic                timeout_hit;
    logic [ID_W-1:0]     next_ptr;

    // Pick the first valid port, scanning upward from rr_ptr (round-robin) or from port 0 (fixed).
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_idx    = '0;
        scan_start  = (RR_MODE != 0) ? int'(rr_ptr) : 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = ID_W'((scan_start + i) % NUM_REQ);
            if (!grant_found && req_valid_i[scan_idx]) begin
                grant_found = 1'b1;
                grant_id    = scan_idx;
            end
        end
    end

    // Gather the granted port's fields. Read data is forced to zero so no stale write data leaks out.
    always_comb begin
        sel_paddr = {pae_hi_i[int'(grant_id)*HI_W +: HI_W], req_addr_i[int'(grant_id)*ADDR_W +: ADDR_W]};
        sel_we    = req_we_i[grant_id];
        sel_data  = sel_we ? req_data_i[int'(grant_id)*DATA_W +: DATA_W] : '0;
    end

    // Accept the granted port. The accept is only offered while idle.
    always_comb begin
        req_ready_o = '0;
        if (state == IDLE && grant_found) begin
            req_ready_o[grant_id] = 1'b1;
        end
    end

    // Completion and timeout conditions. A response in the expiry cycle takes precedence over the timeout.
    always_comb begin
        resp_hs     = mem_resp_valid_i && resp_ready_i[id_q];
        timeout_hit = (TIMEOUT_CYC != 0) && (state == RESP) && !resp_hs &&
                      (cnt_q == CNT_W'(TO_LAST));
        next_ptr    = (int'(id_q) == NUM_REQ - 1) ? '0 : id_q + 1'b1;
    end

    // Response routing. Memory responses pass through to the owner, or are drained while idle or in error return.
    always_comb begin
        resp_valid_o     = '0;
        resp_data_o      = '0;
        resp_error_o     = 1'b0;
        mem_resp_ready_o = 1'b0;
        case (state)
            IDLE: begin
                mem_resp_ready_o = 1'b1;
            end
            RESP: begin
                resp_valid_o[id_q] = mem_resp_valid_i;
                resp_data_o        = mem_resp_data_i;
                resp_error_o       = mem_resp_error_i;
                mem_resp_ready_o   = resp_ready_i[id_q];
            end
            TOERR: begin
                resp_valid_o[id_q] = 1'b1;
                resp_error_o       = 1'b1;
                mem_resp_ready_o   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign mem_req_valid_o = (state == REQ);
    assign mem_req_addr_o  = paddr_q;
    assign mem_req_we_o    = we_q;
    assign mem_req_data_o  = data_q;
    assign busy_o          = (state != IDLE);
    assign timeout_o       = timeout_hit;

    // Transaction FSM. It latches the request, then holds it until memory accepts and the response completes or times out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            id_q    <= '0;
            paddr_q <= '0;
            we_q    <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        id_q    <= grant_id;
                        paddr_q <= sel_paddr;
                        we_q    <= sel_we;
                        data_q  <= sel_data;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready_i) begin
                        cnt_q <= '0;
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (resp_hs) begin
                        rr_ptr <= next_ptr;
                        state  <= IDLE;
                    end else if (timeout_hit) begin
                        state <= TOERR;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                TOERR: begin
                    if (resp_ready_i[id_q]) begin
                        rr_ptr <= next_ptr;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clownfish_mem_arbiter_v3.sv
// tb_clownfish_mem_arbiter_v3
// Runs a round-robin instance and a fixed-priority instance side by side on shared stimulus.
// Expected memory requests and grants are queued as stimulus is driven.
// Each queued entry is consumed when the arbiter produces the matching output.
module tb_clownfish_mem_arbiter_v3;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 32;
    localparam int PADDR_W = 36;
    localparam int DATA_W  = 64;
    localparam int HI_W    = PADDR_W - ADDR_W;
    localparam int TO_CYC  = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
    logic [NUM_REQ-1:0]        req_we = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data = '0;
    logic [NUM_REQ*HI_W-1:0]   pae_hi = '0;
    logic [NUM_REQ-1:0]        resp_ready = '0;
    logic                      mem_req_ready = 1'b0;
    logic                      mem_resp_valid = 1'b0;
    logic [DATA_W-1:0]         mem_resp_data = '0;
    logic                      mem_resp_error = 1'b0;

    logic [NUM_REQ-1:0] r_req_ready, f_req_ready, r_resp_valid, f_resp_valid;
    logic [DATA_W-1:0]  r_resp_data, f_resp_data, r_mem_req_data, f_mem_req_data;
    logic [PADDR_W-1:0] r_mem_req_addr, f_mem_req_addr;
    logic r_resp_error, f_resp_error, r_mem_req_valid, f_mem_req_valid;
    logic r_mem_req_we, f_mem_req_we, r_mem_resp_ready, f_mem_resp_ready;
    logic r_busy, f_busy, r_timeout, f_timeout;

    typedef struct {
        int                 port;
        logic [PADDR_W-1:0] addr;
        logic               we;
        logic [DATA_W-1:0]  data;
    } exp_t;

    exp_t exp_q[$];
    exp_t it;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clownfish_mem_arbiter_v3 #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .PADDR_W(PADDR_W), .DATA_W(DATA_W),
        .RR_MODE(1), .TIMEOUT_CYC(TO_CYC)
    ) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_addr_i(req_addr), .req_we_i(req_we),
        .req_data_i(req_data), .pae_hi_i(pae_hi), .req_ready_o(r_req_ready),
        .resp_valid_o(r_resp_valid), .resp_data_o(r_resp_data), .resp_error_o(r_resp_error),
        .resp_ready_i(resp_ready),
        .mem_req_valid_o(r_mem_req_valid), .mem_req_addr_o(r_mem_req_addr),
        .mem_req_we_o(r_mem_req_we), .mem_req_data_o(r_mem_req_data),
        .mem_req_ready_i(mem_req_ready), .mem_resp_valid_i(mem_resp_valid),
        .mem_resp_data_i(mem_resp_data), .mem_resp_error_i(mem_resp_error),
        .mem_resp_ready_o(r_mem_resp_ready), .busy_o(r_busy), .timeout_o(r_timeout)
    );

    clownfish_mem_arbiter_v3 #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .PADDR_W(PADDR_W), .DATA_W(DATA_W),
        .RR_MODE(0), .TIMEOUT_CYC(TO_CYC)
    ) dut_fx (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_addr_i(req_addr), .req_we_i(req_we),
        .req_data_i(req_data), .pae_hi_i(pae_hi), .req_ready_o(f_req_ready),
        .resp_valid_o(f_resp_valid), .resp_data_o(f_resp_data), .resp_error_o(f_resp_error),
        .resp_ready_i(resp_ready),
        .mem_req_valid_o(f_mem_req_valid), .mem_req_addr_o(f_mem_req_addr),
        .mem_req_we_o(f_mem_req_we), .mem_req_data_o(f_mem_req_data),
        .mem_req_ready_i(mem_req_ready), .mem_resp_valid_i(mem_resp_valid),
        .mem_resp_data_i(mem_resp_data), .mem_resp_error_i(mem_resp_error),
        .mem_resp_ready_o(f_mem_resp_ready), .busy_o(f_busy), .timeout_o(f_timeout)
    );

    // Hard stop in case something wedges outside the bounded loops.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic set_port(input int p, input logic [ADDR_W-1:0] a, input logic [HI_W-1:0] hi,
                            input logic we, input logic [DATA_W-1:0] d);
        req_addr[p*ADDR_W +: ADDR_W] = a;
        pae_hi[p*HI_W +: HI_W]       = hi;
        req_we[p]                    = we;
        req_data[p*DATA_W +: DATA_W] = d;
        req_valid[p]                 = 1'b1;
    endtask

    function automatic exp_t make_exp(input int p);
        exp_t e;
        e.port = p;
        e.addr = {pae_hi[p*HI_W +: HI_W], req_addr[p*ADDR_W +: ADDR_W]};
        e.we   = req_we[p];
        e.data = req_we[p] ? req_data[p*DATA_W +: DATA_W] : '0;
        return e;
    endfunction

    // Called while the arbiter is in REQ. Accepts the request, returns one response, and ends on a negedge in IDLE.
    task automatic complete_txn(input logic [DATA_W-1:0] d);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = d;
        resp_ready     = '1;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        resp_ready     = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = '0; req_we = '0; resp_ready = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_error = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++; if (r_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b want 0", r_busy); end
        checks++; if (r_mem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_req_valid: got %0b want 0", r_mem_req_valid); end
        checks++; if (r_mem_resp_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_mem_resp_ready: got %0b want 1", r_mem_resp_ready); end
        checks++; if (r_mem_req_addr !== '0) begin errors++; $display("[TB] FAIL reset_mem_req_addr: got %h want 0", r_mem_req_addr); end
        checks++; if (r_resp_valid !== '0 || r_timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp: got valid=%b timeout=%b want 0", r_resp_valid, r_timeout); end
        checks++; if (f_mem_resp_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_fx_mem_resp_ready: got %0b want 1", f_mem_resp_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (r_req_ready !== '0 || r_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_release: got ready=%b busy=%b want 0", r_req_ready, r_busy); end
        @(negedge clk);
    endtask

    // Ports 0 and 2 request together. Both arbiters pick port 0 straight out of reset.
    task automatic test_fixed_priority();
        set_port(0, 32'h1000_0100, 4'h5, 1'b0, 64'hDEAD_BEEF_0000_0001);
        set_port(2, 32'h2000_0200, 4'hA, 1'b0, 64'h0000_0000_0000_BEEF);
        exp_q.push_back(make_exp(0));
        #1;
        checks++; if (f_req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL fixed_grant: got %b want 0001", f_req_ready); end
        checks++; if (r_req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL rr_first_grant: got %b want 0001", r_req_ready); end
        @(negedge clk);
        req_valid[0] = 1'b0;
        #1;
        it = exp_q.pop_front();
        checks++; if (r_mem_req_valid !== 1'b1 || r_mem_req_addr !== it.addr) begin errors++; $display("[TB] FAIL fixed_mem_req: got v=%b addr=%h want 1 %h", r_mem_req_valid, r_mem_req_addr, it.addr); end
        checks++; if (f_mem_req_addr !== it.addr) begin errors++; $display("[TB] FAIL fixed_fx_addr: got %h want %h", f_mem_req_addr, it.addr); end
        checks++; if (r_mem_req_we !== it.we || r_mem_req_data !== it.data) begin errors++; $display("[TB] FAIL read_data_zero: got we=%b data=%h want %b %h", r_mem_req_we, r_mem_req_data, it.we, it.data); end
        checks++; if (r_req_ready !== '0) begin errors++; $display("[TB] FAIL no_grant_in_req: got %b want 0000", r_req_ready); end
        req_valid = '0;
        complete_txn(64'h1111);
    endtask

    // After port 0 completes, the round-robin pointer sits at 1, while fixed priority still prefers port 0.
    task automatic test_fixed_vs_rr();
        exp_t e_rr, e_fx;
        set_port(0, 32'h1000_0180, 4'h5, 1'b0, '0);
        set_port(2, 32'h2000_0280, 4'hA, 1'b0, '0);
        e_fx = make_exp(0);
        e_rr = make_exp(2);
        exp_q.push_back(e_rr);
        #1;
        checks++; if (f_req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL fx_vs_rr_fixed: got %b want 0001", f_req_ready); end
        checks++; if (r_req_ready !== 4'b0100) begin errors++; $display("[TB] FAIL fx_vs_rr_rr: got %b want 0100", r_req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        it = exp_q.pop_front();
        checks++; if (r_mem_req_addr !== it.addr) begin errors++; $display("[TB] FAIL fx_vs_rr_rr_addr: got %h want %h", r_mem_req_addr, it.addr); end
        checks++; if (f_mem_req_addr !== e_fx.addr) begin errors++; $display("[TB] FAIL fx_vs_rr_fx_addr: got %h want %h", f_mem_req_addr, e_fx.addr); end
        complete_txn(64'h2222);
    endtask

    // All four ports request continuously and memory answers immediately. The grant must rotate 0,1,2,3,0.
    task automatic test_rr_rotation();
        int ptr;
        int seen;
        exp_t cur;
        do_reset();
        for (int p = 0; p < NUM_REQ; p++) begin
            set_port(p, 32'h4000_0000 + 32'(p * 'h40), 4'(p + 1), 1'b0, '0);
        end
        ptr = 0;
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back(make_exp(ptr));
            ptr = (ptr + 1) % NUM_REQ;
        end
        mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = 64'hCAFE; resp_ready = '1;
        seen = 0;
        cur = make_exp(0);
        for (int cyc = 0; cyc < 40 && seen < 5; cyc++) begin
            #1;
            if (r_req_ready !== '0) begin
                cur = exp_q.pop_front();
                seen++;
                checks++; if (r_req_ready !== (4'b0001 << cur.port)) begin errors++; $display("[TB] FAIL rr_order: got %b want port %0d", r_req_ready, cur.port); end
                checks++; if (f_req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL rr_fx_grant: got %b want 0001", f_req_ready); end
            end else if (r_mem_req_valid === 1'b1) begin
                checks++; if (r_mem_req_addr !== cur.addr) begin errors++; $display("[TB] FAIL rr_addr: got %h want %h", r_mem_req_addr, cur.addr); end
            end else if (r_resp_valid !== '0) begin
                checks++; if (r_resp_valid !== (4'b0001 << cur.port) || r_resp_data !== 64'hCAFE) begin errors++; $display("[TB] FAIL rr_resp: got %b %h want port %0d cafe", r_resp_valid, r_resp_data, cur.port); end
            end
            @(negedge clk);
        end
        checks++; if (seen != 5) begin errors++; $display("[TB] FAIL rr_grant_count: got %0d want 5", seen); end
        req_valid = '0;
        repeat (4) @(negedge clk);
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; resp_ready = '0;
        exp_q.delete();
        @(negedge clk);
    endtask

    // A port 1 write must hold its latched fields while memory stalls, even after the requester changes its data.
    task automatic test_write_stall();
        set_port(1, 32'h8000_0040, 4'h3, 1'b1, 64'hA5A5_5A5A_0F0F_F0F0);
        exp_q.push_back(make_exp(1));
        #1;
        checks++; if (r_req_ready !== 4'b0010 || f_req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL wr_grant: got rr=%b fx=%b want 0010", r_req_ready, f_req_ready); end
        @(negedge clk);
        req_valid = '0;
        req_data[1*DATA_W +: DATA_W] = 64'h1234_1234_1234_1234;
        #1;
        it = exp_q.pop_front();
        checks++; if (it.addr !== 36'h3_8000_0040 || r_mem_req_addr !== it.addr) begin errors++; $display("[TB] FAIL wr_addr: got %h want 380000040", r_mem_req_addr); end
        for (int k = 0; k < 5; k++) begin
            checks++; if (r_mem_req_valid !== 1'b1 || r_mem_req_we !== 1'b1) begin errors++; $display("[TB] FAIL wr_hold_ctl: cycle %0d got v=%b we=%b want 1 1", k, r_mem_req_valid, r_mem_req_we); end
            checks++; if (r_mem_req_data !== it.data || r_mem_req_addr !== it.addr) begin errors++; $display("[TB] FAIL wr_hold_data: cycle %0d got %h %h want %h %h", k, r_mem_req_addr, r_mem_req_data, it.addr, it.data); end
            @(negedge clk);
            #1;
        end
        complete_txn(64'h3333);
    endtask

    // Port 2 reads and memory never answers. The timeout pulse must land on the 16th RESP cycle, followed by an error return.
    task automatic test_timeout();
        set_port(2, 32'h0000_1230, 4'h7, 1'b0, '0);
        #1;
        checks++; if (r_req_ready !== 4'b0100) begin errors++; $display("[TB] FAIL to_grant: got %b want 0100", r_req_ready); end
        @(negedge clk);
        req_valid = '0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        for (int n = 1; n <= TO_CYC; n++) begin
            #1;
            checks++; if (r_timeout !== (n == TO_CYC) || f_timeout !== (n == TO_CYC)) begin errors++; $display("[TB] FAIL to_pulse: resp cycle %0d got rr=%b fx=%b want %b", n, r_timeout, f_timeout, (n == TO_CYC)); end
            @(negedge clk);
        end
        #1;
        checks++; if (r_resp_valid !== 4'b0100 || r_resp_error !== 1'b1) begin errors++; $display("[TB] FAIL to_err: got v=%b err=%b want 0100 1", r_resp_valid, r_resp_error); end
        checks++; if (r_resp_data !== '0 || r_mem_resp_ready !== 1'b1 || r_timeout !== 1'b0) begin errors++; $display("[TB] FAIL to_err_data: got d=%h mrr=%b to=%b want 0 1 0", r_resp_data, r_mem_resp_ready, r_timeout); end
        @(negedge clk);
        #1;
        checks++; if (r_resp_valid !== 4'b0100) begin errors++; $display("[TB] FAIL to_err_hold: got %b want 0100", r_resp_valid); end
        resp_ready = 4'b0100;
        @(negedge clk);
        resp_ready = '0;
        mem_resp_valid = 1'b1;
        mem_resp_data = 64'h5555;
        #1;
        checks++; if (r_busy !== 1'b0 || r_resp_valid !== '0 || r_mem_resp_ready !== 1'b1) begin errors++; $display("[TB] FAIL to_drain: got busy=%b v=%b mrr=%b want 0 0000 1", r_busy, r_resp_valid, r_mem_resp_ready); end
        @(negedge clk);
        mem_resp_valid = 1'b0;
    endtask

    // Port 3 holds off its response for three cycles. Memory must be back-pressured until the owner is ready.
    task automatic test_resp_backpressure();
        logic [DATA_W-1:0] d;
        d = 64'h0123_4567_89AB_CDEF;
        set_port(3, 32'h0000_9000, 4'h1, 1'b0, '0);
        exp_q.push_back(make_exp(3));
        #1;
        checks++; if (r_req_ready !== 4'b1000) begin errors++; $display("[TB] FAIL bp_grant: got %b want 1000", r_req_ready); end
        @(negedge clk);
        req_valid = '0;
        mem_req_ready = 1'b1;
        #1;
        it = exp_q.pop_front();
        checks++; if (r_mem_req_addr !== it.addr) begin errors++; $display("[TB] FAIL bp_addr: got %h want %h", r_mem_req_addr, it.addr); end
        @(negedge clk);
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data = d;
        resp_ready = 4'b0111;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (r_resp_valid !== 4'b1000 || r_mem_resp_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_stall: cycle %0d got v=%b mrr=%b want 1000 0", k, r_resp_valid, r_mem_resp_ready); end
            checks++; if (r_resp_data !== d || r_busy !== 1'b1) begin errors++; $display("[TB] FAIL bp_data: cycle %0d got %h busy=%b want %h 1", k, r_resp_data, r_busy, d); end
            @(negedge clk);
        end
        resp_ready = 4'b1000;
        #1;
        checks++; if (r_mem_resp_ready !== 1'b1 || r_resp_valid !== 4'b1000) begin errors++; $display("[TB] FAIL bp_release: got mrr=%b v=%b want 1 1000", r_mem_resp_ready, r_resp_valid); end
        @(negedge clk);
        mem_resp_valid = 1'b0;
        resp_ready = '0;
        #1;
        checks++; if (r_busy !== 1'b0) begin errors++; $display("[TB] FAIL bp_done: got busy=%b want 0", r_busy); end
        @(negedge clk);
    endtask

    // Reset lands in REQ while rr_ptr is 2. Everything must clear, and the next grant must scan from port 0 again.
    task automatic test_reset_mid();
        set_port(1, 32'h0000_A000, 4'h2, 1'b0, '0);
        #1;
        checks++; if (r_req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL rm_pre_grant: got %b want 0010", r_req_ready); end
        @(negedge clk);
        req_valid = '0;
        complete_txn(64'h4444);
        set_port(2, 32'h0000_B000, 4'h6, 1'b1, 64'h7777);
        @(negedge clk);
        req_valid = '0;
        #1;
        checks++; if (r_busy !== 1'b1 || r_mem_req_valid !== 1'b1) begin errors++; $display("[TB] FAIL rm_in_req: got busy=%b v=%b want 1 1", r_busy, r_mem_req_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (r_busy !== 1'b0 || r_mem_req_valid !== 1'b0 || r_req_ready !== '0) begin errors++; $display("[TB] FAIL rm_ctl: got busy=%b v=%b rdy=%b want 0", r_busy, r_mem_req_valid, r_req_ready); end
        checks++; if (r_mem_req_addr !== '0 || r_mem_req_data !== '0 || r_mem_resp_ready !== 1'b1) begin errors++; $display("[TB] FAIL rm_regs: got a=%h d=%h mrr=%b want 0 0 1", r_mem_req_addr, r_mem_req_data, r_mem_resp_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        set_port(1, 32'h0000_C000, 4'h2, 1'b0, '0);
        set_port(3, 32'h0000_D000, 4'h4, 1'b0, '0);
        #1;
        checks++; if (r_req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL rm_post_grant: got %b want 0010", r_req_ready); end
        @(negedge clk);
        req_valid = '0;
        complete_txn(64'h8888);
    endtask

    // Scenario sequence.
    initial begin
        $display("[TB] starting clownfish_mem_arbiter_v3 bench");
        test_reset();
        test_fixed_priority();
        test_fixed_vs_rr();
        test_rr_rotation();
        test_write_stall();
        test_timeout();
        test_resp_backpressure();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
